// File: rtl/div_unit.sv
// div_unit: radix-2 restoring signed/unsigned divider with cancel; optional DIV_ZERO_FAST_EN skips the iteration loop on a zero divisor
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] acc, rem, dmag;
   logic qneg, rneg, zero;
   logic [WIDTH-1:0] a_mag, b_mag, acc_nx, rem_nx, q_fix, r_fix;
   logic [WIDTH:0] rs, diff;
   assign in_ready  = (state == IDLE) & ~cancel;
   assign out_valid = (state == DONE);
   assign a_mag  = (in_signed & dividend[WIDTH-1]) ? -dividend : dividend;
   assign b_mag  = (in_signed & divisor[WIDTH-1]) ? -divisor : divisor;
   assign rs     = {rem, acc[WIDTH-1]};
   assign diff   = rs - {1'b0, dmag};
   assign acc_nx = {acc[WIDTH-2:0], ~diff[WIDTH]};
   assign rem_nx = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
   assign q_fix  = zero ? '1 : (qneg ? -acc_nx : acc_nx);
   assign r_fix  = rneg ? -rem_nx : rem_nx;
   // control FSM, one quotient bit per BUSY cycle, sign fix folded into the last iteration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         rem         <= '0;
         dmag        <= '0;
         qneg        <= 1'b0;
         rneg        <= 1'b0;
         zero        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid & in_ready) begin
               acc  <= a_mag;
               rem  <= '0;
               dmag <= b_mag;
               qneg <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               rneg <= in_signed & dividend[WIDTH-1];
               zero <= (divisor == '0);
               cnt  <= CW'(WIDTH-1);
`ifdef DIV_ZERO_FAST_EN
               if (divisor == '0) begin
                  state       <= DONE;
                  quotient    <= '1;
                  remainder   <= dividend;
                  div_by_zero <= 1'b1;
               end else state <= BUSY;
`else
               state <= BUSY;
`endif
            end
            BUSY: if (cancel) state <= IDLE;
            else begin
               acc <= acc_nx;
               rem <= rem_nx;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state       <= DONE;
                  quotient    <= q_fix;
                  remainder   <= r_fix;
                  div_by_zero <= zero;
               end
            end
            DONE: if (cancel | out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit (directed vectors, latency, backpressure, cancel, async reset)
module tb_div_unit;
   localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   logic clk = 0, reset = 1, in_valid = 0, in_signed = 0, cancel = 0, out_ready = 1;
   logic [W-1:0] dividend = 0, divisor = 0;
   logic in_ready, out_valid, div_by_zero;
   logic [W-1:0] quotient, remainder;
   int vectors = 0, miscompares = 0, cyc = 0;
   typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic z; int c;} exp_t;
   typedef struct {logic s; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] q; logic [W-1:0] r; logic z;} vec_t;
   exp_t sb[$];
   bit seen = 0, unexp = 0;

   div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .dividend(dividend), .divisor(divisor), .cancel(cancel),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // monitor: first-assertion latency and result values against the queue head
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            if (!unexp) begin
               chk("unexpected out_valid", 64'(out_valid), 64'(0));
               unexp = 1;
            end
         end else begin
            if (!seen) begin
               chk("latency", 64'(cyc), 64'(sb[0].c));
               seen = 1;
            end
            if (out_ready) begin
               chk("quotient", 64'(quotient), 64'(sb[0].q));
               chk("remainder", 64'(remainder), 64'(sb[0].r));
               chk("div_by_zero", 64'(div_by_zero), 64'(sb[0].z));
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input bit push, output int n);
      bit got = 0;
      in_valid = 1; in_signed = s; dividend = a; divisor = b;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
      end
      if (!got) chk("accept timeout", 64'(in_ready), 64'(1));
      n = cyc;
      if (push && got) sb.push_back('{eq, er, ez, n + ((ez && FAST) ? 1 : W + 1)});
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain timeout", 64'(sb.size()), 64'(0));
         sb.delete();
         seen = 0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit hit;
      vec_t tbl[11];
      tbl = '{
         '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
         '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0},
         '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0},
         '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0},
         '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
         '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0},
         '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0},
         '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0},
         '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1},
         '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1},
         '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0}
      };
      #12;
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset quotient", 64'(quotient), 64'(0));
      chk("reset remainder", 64'(remainder), 64'(0));
      chk("reset div_by_zero", 64'(div_by_zero), 64'(0));
      @(negedge clk) reset = 0;
      @(negedge clk);
      chk("idle in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         issue(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 1, n);
         drain();
      end

      out_ready = 0;
      issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1, n);
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         hit = out_valid;
      end
      repeat (5) begin
         @(negedge clk);
         chk("hold out_valid", 64'(out_valid), 64'(1));
         chk("hold quotient", 64'(quotient), 64'(14));
         chk("hold remainder", 64'(remainder), 64'(2));
         chk("hold in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("post handshake in_ready", 64'(in_ready), 64'(1));
      chk("post handshake out_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;

      issue(0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, n);
      while (cyc != n + 10) begin
         @(posedge clk); #1;
      end
      cancel = 1;
      @(negedge clk);
      chk("cancel in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      cancel = 0;
      @(negedge clk);
      chk("after cancel in_ready", 64'(in_ready), 64'(1));
      chk("after cancel out_valid", 64'(out_valid), 64'(0));
      repeat (40) @(negedge clk);

      @(posedge clk); #1;
      in_valid = 1; cancel = 1; dividend = 32'd100; divisor = 32'd7; in_signed = 0;
      @(negedge clk);
      chk("cancel+valid in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      in_valid = 0; cancel = 0;
      @(negedge clk);
      chk("cancel+valid no accept", 64'(in_ready), 64'(1));
      repeat (40) @(negedge clk);

      @(posedge clk); #1;
      issue(0, 32'd100, 32'd7, 32'd0, 32'd0, 0, 0, n);
      repeat (5) @(posedge clk);
      #2 reset = 1;
      #1;
      chk("async reset out_valid", 64'(out_valid), 64'(0));
      chk("async reset quotient", 64'(quotient), 64'(0));
      @(negedge clk) reset = 0;
      @(negedge clk);
      chk("after reset in_ready", 64'(in_ready), 64'(1));
      repeat (40) @(negedge clk);

      @(posedge clk); #1;
      issue(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1, n);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  unit can accept operands this cycle.
REQ-006 in_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with operands.
REQ-007 dividend  input  WIDTH  numerator.
REQ-008 divisor  input  WIDTH  denominator.
REQ-009 cancel  input  1  abort in-flight operation (pipeline flush).
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 quotient  output  WIDTH  result quotient.
REQ-013 remainder  output  WIDTH  result remainder.
REQ-014 div_by_zero  output  1  flag; result came from a zero divisor; valid while out_valid.

Function
REQ-015 States IDLE, BUSY, DONE; in_ready = (state==IDLE) & ~cancel; out_valid = (state==DONE).
REQ-016 Accept on in_valid & in_ready: latch operands, in_signed and zero-divisor flag; IDLE->BUSY.
REQ-017 BUSY: radix-2 restoring division on operand magnitudes, one quotient bit per cycle, exactly WIDTH cycles, counter from WIDTH-1 down to 0; last iteration applies sign fix and moves to DONE.
REQ-018 Latency: handshake in cycle n -> out_valid first high in cycle n+WIDTH+1.
REQ-019 DONE: quotient, remainder, div_by_zero held stable until out_ready; out_valid & out_ready -> IDLE next cycle; in_ready stays low throughout DONE (no same-cycle accept).
REQ-020 Signed: quotient negated if operand signs differ; remainder takes the dividend's sign; |remainder| < |divisor|.
REQ-021 Signed overflow: most-negative / -1 -> quotient most-negative (wraps), remainder 0, div_by_zero 0.
REQ-022 Zero divisor, either mode: quotient all ones, remainder = dividend, div_by_zero 1.
REQ-023 cancel in BUSY or DONE -> IDLE next cycle, result discarded, out_valid low from next cycle.
REQ-024 cancel together with in_valid in IDLE: no accept; state stays IDLE.
REQ-025 cancel together with out_ready in DONE: treated as a handshake; both lead to IDLE.

Reset
REQ-026 On reset assertion, independent of clk: state IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, out_valid 0, in_ready 1 once reset and cancel are low.
REQ-027 Reset mid-operation (BUSY or DONE) drops the operation; no result emitted after release.

Configuration
REQ-028 Macro DIV_ZERO_FAST_EN defined: zero-divisor accept goes IDLE->DONE directly and out_valid is high in cycle n+1, result per REQ-022.
REQ-029 Macro DIV_ZERO_FAST_EN absent: zero divisor runs the full WIDTH-cycle BUSY sequence with REQ-018 latency; result values identical to REQ-022.

Verification
REQ-030 WIDTH=32, unsigned 100/7 accepted cycle 0 -> out_valid cycle 33, quotient 14, remainder 2, div_by_zero 0.
REQ-031 Signed -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); signed 7/-2 -> quotient -3, remainder 1.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-033 Divisor 0, dividend 0x1234: quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1; out_valid cycle 1 with DIV_ZERO_FAST_EN, cycle 33 without.
REQ-034 out_ready held low 5 cycles after result -> outputs stable, in_ready 0; out_ready high -> IDLE, in_ready 1 next cycle.
REQ-035 cancel in cycle 10 of a divide -> out_valid never asserts, in_ready 1 in cycle 11; async reset mid-BUSY -> in_ready 1 once reset and cancel are low, no stale result.
